dot_ctrl: RTL
=============

DOT_CTRL -- requirements
Module: dot_ctrl

Interface
REQ-001 SHALL have parameter N_PIX, default 64, meaning number of output positions per layer pass (1..2^PIX_W).
REQ-002 SHALL have parameter PIX_W, default 6, meaning pixel address width.
REQ-003 SHALL have parameter N_CS, default 12, meaning weight chunk selects per pixel (cs values 0..N_CS-1, N_CS <= 16).
REQ-004 SHALL have parameter TMO, default 32, meaning max cycles to wait for ch_valid before error.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  input  1  one-cycle pulse; begins a pass when idle.
REQ-008 SHALL have port abort  input  1  level; returns FSM to IDLE next cycle.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse at pass completion.
REQ-011 SHALL have port err  output  1  sticky timeout flag, cleared by start.
REQ-012 SHALL have port in_addr  output  PIX_W  feature-buffer read address (current pixel).
REQ-013 SHALL have port in_rdy  input  1  feature vector for in_addr stable on channel d input.
REQ-014 SHALL have port ch_load  output  1  load to dot channel(s).
REQ-015 SHALL have port ch_cs  output  4  weight chunk select to dot channel(s).
REQ-016 SHALL have port ch_valid  input  1  dot-product result valid.
REQ-017 SHALL have port ch_q  input  `data_len  dot-product result.
REQ-018 SHALL have ports out_we  output  1, out_addr  output  PIX_W, out_data  output  `data_len  result write port.

Function
REQ-019 SHALL implement states IDLE, FETCH, RUN, WAIT, WRITE, GAP, DONE.
REQ-020 IDLE: on start, clear pix counter and err, go FETCH; start while busy SHALL be ignored.
REQ-021 FETCH: in_addr = pix; hold until in_rdy=1, then go RUN with ch_cs=0.
REQ-022 RUN: ch_load=1; ch_cs increments by 1 per cycle from 0 to N_CS-1, then holds N_CS-1 and goes WAIT.
REQ-023 WAIT: ch_load=1, ch_cs held; on ch_valid=1 register ch_q into out_data and go WRITE; tmo counter increments each WAIT cycle.
REQ-024 WAIT timeout: when tmo reaches TMO-1 without ch_valid, set err=1 and go GAP, writing nothing for that pixel.
REQ-025 WRITE: out_we=1 for exactly one cycle, out_addr = pix, out_data = captured value; go GAP.
REQ-026 GAP: ch_load=0 for exactly one cycle (guarantees fresh load rising edge per pixel); if pix==N_PIX-1 go DONE, else pix+1 and go FETCH.
REQ-027 DONE: done=1 one cycle, then IDLE; pix SHALL NOT wrap past N_PIX-1.
REQ-028 ch_load SHALL be 0 in IDLE, FETCH, GAP, DONE; ch_cs SHALL be 0 outside RUN/WAIT.
REQ-029 Minimum per-pixel latency: 1 FETCH + N_CS RUN + WAIT + 1 WRITE + 1 GAP cycles.
REQ-030 abort SHALL take priority over every transition; out_we, ch_load, done SHALL be 0 the cycle after abort; err retained.
REQ-031 ch_valid outside WAIT SHALL be ignored.

Reset
REQ-032 rst_n=0 SHALL asynchronously force IDLE, pix=0, tmo=0, ch_cs=0, and busy, done, err, ch_load, out_we, out_addr, out_data, in_addr all 0.
REQ-033 Reset deassertion mid-pass SHALL leave the block in IDLE awaiting start.

Structure
REQ-034 State encodings and N_CS default SHALL live in a shared constants include alongside num_data.v; `data_len taken from num_data.v.
REQ-035 Single module; optional sub-module dot_tmo (timeout counter) SHALL be the only child.

Verification
REQ-036 N_PIX=4, in_rdy=1, channel model asserts ch_valid 12 cycles after load rise, q=pix*3 -> out_we x4 at addr 0..3 data 0,3,6,9, one done, err=0.
REQ-037 in_rdy held low 5 cycles in pixel 2 -> ch_load stays 0 those cycles, in_addr=2, results unchanged.
REQ-038 Channel never asserts ch_valid for pixel 1 -> err=1 after TMO WAIT cycles, no write at addr 1, pass still completes with done.
REQ-039 abort during RUN of pixel 2 -> next cycle IDLE, busy=0, ch_load=0, no done; subsequent start completes normally, err cleared.
REQ-040 rst_n low during WAIT -> all outputs 0 immediately (before clock edge); start pulse while busy -> no restart, pix sequence unaffected.
REQ-041 Check ch_load low exactly one cycle between consecutive pixels and ch_cs sequence 0..11 per pixel.

Source files
------------

// File: rtl/dot_ctrl_pkg.sv
// rtl/dot_ctrl_pkg.sv - shared constants, state encoding and helpers for the dot-product controller
package dot_ctrl_pkg;

  localparam int DATA_LEN = 16;
  localparam int CS_W     = 4;
  localparam int N_CS_DEF = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_RUN   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WRITE = 3'd4,
    ST_GAP   = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  // The channel keeps its load high from RUN until the result is written back.
  function automatic logic st_loads(input state_t s);
    return (s == ST_RUN) || (s == ST_WAIT) || (s == ST_WRITE);
  endfunction

  function automatic logic st_cs_live(input state_t s);
    return (s == ST_RUN) || (s == ST_WAIT);
  endfunction

endpackage

// File: rtl/dot_ctrl_if.sv
// rtl/dot_ctrl_if.sv - feature-buffer, dot-channel and result-write signals of the controller
interface dot_ctrl_if
  import dot_ctrl_pkg::*;
#(
  parameter int PIX_W = 6
);

  logic [PIX_W-1:0]    in_addr;
  logic                in_rdy;
  logic                ch_load;
  logic [CS_W-1:0]     ch_cs;
  logic                ch_valid;
  logic [DATA_LEN-1:0] ch_q;
  logic                out_we;
  logic [PIX_W-1:0]    out_addr;
  logic [DATA_LEN-1:0] out_data;

  modport master (
    output in_addr, ch_load, ch_cs, out_we, out_addr, out_data,
    input  in_rdy, ch_valid, ch_q
  );

  modport slave (
    input  in_addr, ch_load, ch_cs, out_we, out_addr, out_data,
    output in_rdy, ch_valid, ch_q
  );

endinterface

// File: rtl/dot_ctrl_tmo.sv
// rtl/dot_ctrl_tmo.sv - WAIT-state timeout counter; expires on the TMO-th enabled cycle
module dot_tmo #(
  parameter int TMO = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int            TW   = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [TW-1:0] LAST = TW'(TMO - 1);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = i_en && (r_cnt == LAST);

endmodule

// File: rtl/dot_ctrl.sv
// rtl/dot_ctrl.sv - sequences one layer pass: per pixel fetch, chunked dot product, result write
module dot_ctrl
  import dot_ctrl_pkg::*;
#(
  parameter int N_PIX = 64,
  parameter int PIX_W = 6,
  parameter int N_CS  = N_CS_DEF,
  parameter int TMO   = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       err,
  dot_ctrl_if.master bus
);

  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(N_PIX - 1);
  localparam logic [CS_W-1:0]  CS_LAST  = CS_W'(N_CS - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PIX_W-1:0]    r_pix;
  logic [CS_W-1:0]     r_cs;
  logic [DATA_LEN-1:0] r_data;
  logic                r_err;

  logic w_go;
  logic w_capture;
  logic w_timeout;
  logic w_adv;
  logic w_tmo_exp;
  logic w_tmo_en;
  logic w_tmo_clr;

  assign w_tmo_en  = (r_state == ST_WAIT);
  assign w_tmo_clr = (r_state != ST_WAIT);

  dot_tmo #(
    .TMO (TMO)
  ) u_tmo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_tmo_clr),
    .i_en     (w_tmo_en),
    .o_expire (w_tmo_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_go        = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_adv       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_FETCH;
          w_go        = 1'b1;
        end
      end
      ST_FETCH: begin
        if (bus.in_rdy) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_cs == CS_LAST) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A result arriving on the last permitted cycle still wins over the timeout.
        if (bus.ch_valid) begin
          w_state_nxt = ST_WRITE;
          w_capture   = 1'b1;
        end else if (w_tmo_exp) begin
          w_state_nxt = ST_GAP;
          w_timeout   = 1'b1;
        end
      end
      ST_WRITE: begin
        w_state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (r_pix == PIX_LAST) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_FETCH;
          w_adv       = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_go        = 1'b0;
      w_capture   = 1'b0;
      w_timeout   = 1'b0;
      w_adv       = 1'b0;
    end

    busy         = (r_state != ST_IDLE);
    done         = (r_state == ST_DONE);
    err          = r_err;
    bus.in_addr  = r_pix;
    bus.ch_load  = st_loads(r_state);
    bus.ch_cs    = st_cs_live(r_state) ? r_cs : '0;
    bus.out_we   = (r_state == ST_WRITE);
    bus.out_addr = r_pix;
    bus.out_data = r_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix  <= '0;
      r_cs   <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_go) begin
        r_pix <= '0;
        r_err <= 1'b0;
      end else if (w_adv) begin
        r_pix <= r_pix + 1'b1;
      end

      if (w_timeout) begin
        r_err <= 1'b1;
      end

      if (w_capture) begin
        r_data <= bus.ch_q;
      end

      // Chunk select counts through RUN, parks on the last chunk in WAIT, else rests at zero.
      if (st_cs_live(w_state_nxt)) begin
        if ((r_state == ST_RUN) && (r_cs != CS_LAST)) begin
          r_cs <= r_cs + 1'b1;
        end
      end else begin
        r_cs <= '0;
      end
    end
  end

endmodule
